// File: rtl/mult8_secuencial_pkg.sv
// mult8_secuencial_pkg
// Shared definitions for the sequential 8x8 multiplier:
//   - state encoding of the control FSM (code 3 is illegal, recovers to IDLE)
//   - datapath width and iteration count
//   - cla4(): one 4-bit carry-lookahead slice used by the gate-level adder
package mult8_secuencial_pkg;

    localparam int N_BITS = 8;
    localparam int N_ITER = 8;

    // Counter value seen during the final (8th) iteration.
    localparam logic [2:0] CNT_LAST = 3'(N_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // 4-bit carry-lookahead add; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
        logic [3:0] g;
        logic [3:0] pr;
        logic [4:0] c;
        g    = x & y;
        pr   = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (pr[0] & ci);
        c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & ci);
        c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0])
             | (pr[2] & pr[1] & pr[0] & ci);
        c[4] = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1])
             | (pr[3] & pr[2] & pr[1] & g[0])
             | (pr[3] & pr[2] & pr[1] & pr[0] & ci);
        return {c[4], pr ^ c[3:0]};
    endfunction

endpackage

// File: rtl/mult8_secuencial_sum8.sv
// SUM8_LOGICO
// Purely combinational 8-bit adder built from two 4-bit carry-lookahead
// slices, with the carry rippling from the low slice into the high slice.
// Ports:
//   a, b  [7:0] : addends
//   ci          : carry in
//   s     [7:0] : sum
//   co          : carry out
// PwrC selects power accounting of the gate-level adder; the RTL view of
// the adder is identical for every value.
module SUM8_LOGICO
    import mult8_secuencial_pkg::*;
#(
    parameter int PwrC = 0
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [4:0] lo_s;
    logic [4:0] hi_s;

    assign lo_s = cla4(a[3:0], b[3:0], ci);
    assign hi_s = cla4(a[7:4], b[7:4], lo_s[4]);

    assign s  = {hi_s[3:0], lo_s[3:0]};
    assign co = hi_s[4];

    // Hook point for gate-level power accounting; carries no RTL logic.
    if (PwrC != 0) begin : g_pwr_count
    end

endmodule

// File: rtl/mult8_secuencial.sv
// mult8_secuencial
// Sequential 8x8 unsigned shift-and-add multiplier with start/done handshake.
// One iteration per clock in RUN, 8 iterations, product registered in p.
// Ports:
//   clk      : rising-edge clock
//   reset_L  : asynchronous active-low reset
//   start    : request a multiply (sampled only in IDLE)
//   a, b     : multiplicand / multiplier, sampled with start
//   busy     : high in RUN and DONE
//   done     : one-cycle pulse while in DONE
//   p [15:0] : product, loaded on entry to DONE and held otherwise
module mult8_secuencial
    import mult8_secuencial_pkg::*;
#(
    parameter int PwrC = 0
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          start,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    output logic          busy,
    output logic          done,
    output logic [15:0]   p
);

    state_e              st_q, st_d;
    logic [N_BITS-1:0]   a_r_q, a_r_d;
    logic [N_BITS-1:0]   h_q, h_d;
    logic [N_BITS-1:0]   q_q, q_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [15:0]         p_q, p_d;

    logic [N_BITS-1:0]   sum_s;
    logic                cy_s;

    // Adder is always connected: H + A_r, no carry in.
    SUM8_LOGICO #(
        .PwrC (PwrC)
    ) sum8 (
        .a  (h_q),
        .b  (a_r_q),
        .ci (1'b0),
        .s  (sum_s),
        .co (cy_s)
    );

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st_q  <= ST_IDLE;
            a_r_q <= 8'h00;
            h_q   <= 8'h00;
            q_q   <= 8'h00;
            cnt_q <= 3'd0;
            p_q   <= 16'h0000;
        end else begin
            st_q  <= st_d;
            a_r_q <= a_r_d;
            h_q   <= h_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        st_d  = st_q;
        a_r_d = a_r_q;
        h_d   = h_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    a_r_d = a;
                    q_d   = b;
                    h_d   = 8'h00;
                    cnt_d = 3'd0;
                    st_d  = ST_RUN;
                end else begin
                    st_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Shift right by one; the adder carry becomes the new top bit
                // when the current multiplier bit is set.
                if (q_q[0]) begin
                    {h_d, q_d} = {cy_s, sum_s, q_q[7:1]};
                end else begin
                    {h_d, q_d} = {1'b0, h_q, q_q[7:1]};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    p_d  = {h_d, q_d};
                    st_d = ST_DONE;
                end else begin
                    st_d = ST_RUN;
                end
            end
            ST_DONE: begin
                st_d = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state and product.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (st_q)
            ST_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            ST_RUN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign p = p_q;

endmodule

// File: tb/tb_mult8_secuencial.sv
// tb_mult8_secuencial
// Self-checking bench: table of directed products, hand sequences for
// reset mid-RUN, busy lockout and back-to-back starts, then random pairs.
module tb_mult8_secuencial;

    logic        clk;
    logic        reset_L;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int n_total = 0;
    int n_pass  = 0;

    mult8_secuencial #(.PwrC(0)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .p       (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one multiply from IDLE; checks done timing, pulse width, busy fall and p.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] exp, input string name);
        int done_cnt;
        int done_edge;
        logic [15:0] p_at_done;
        done_cnt  = 0;
        done_edge = -1;
        p_at_done = 16'hxxxx;
        @(posedge clk); #1;
        start = 1'b1; a = va; b = vb;
        @(posedge clk); #1;           // edge 0
        start = 1'b0; a = 8'h00; b = 8'h00;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = k;
                    p_at_done = p;
                end
            end
            if (k == 9) chk({name, " busy_fall"}, {15'd0, busy}, 16'd0);
        end
        chk({name, " done_edge"}, 16'(done_edge), 16'd8);
        chk({name, " done_cnt"}, 16'(done_cnt), 16'd1);
        chk({name, " p"}, p_at_done, exp);
    endtask

    vec_t vecs[9];

    initial begin
        logic [7:0] ra, rb;
        logic [7:0] opa[0:2];
        logic [7:0] opb[0:2];
        int         dcnt;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'h00,  8'hA5,  16'h0000};
        vecs[2] = '{8'h01,  8'h80,  16'h0080};
        vecs[3] = '{8'hFF,  8'hFF,  16'hFE01};
        vecs[4] = '{8'h03,  8'h05,  16'h000F};
        vecs[5] = '{8'h80,  8'h02,  16'h0100};
        vecs[6] = '{8'hAA,  8'h55,  16'h3872};
        vecs[7] = '{8'h0F,  8'h10,  16'h00F0};
        vecs[8] = '{8'd200, 8'd200, 16'h9C40};

        reset_L = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        #1;
        chk("reset busy", {15'd0, busy}, 16'd0);
        chk("reset done", {15'd0, done}, 16'd0);
        chk("reset p",    p, 16'h0000);
        #20;
        reset_L = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Reset mid-RUN: FF x FF, reset asserted right after edge 4
        @(posedge clk); #1;
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk); #1;           // edge 0
        start = 1'b0;
        repeat (4) @(posedge clk);    // edge 4
        #1;
        chk("midrun busy before reset", {15'd0, busy}, 16'd1);
        reset_L = 1'b0;
        #1;
        chk("midrun reset busy", {15'd0, busy}, 16'd0);
        chk("midrun reset done", {15'd0, done}, 16'd0);
        chk("midrun reset p",    p, 16'h0000);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post reset idle busy", {15'd0, busy}, 16'd0);
        do_op(8'd3, 8'd5, 16'h000F, "post reset 3x5");

        // Busy lockout: 2x3, with 7x7 requested at edges 3 and 8
        dcnt = 0;
        @(posedge clk); #1;
        start = 1'b1; a = 8'd2; b = 8'd3;
        @(posedge clk); #1;           // edge 0
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3 || k == 8) begin
                start = 1'b1; a = 8'd7; b = 8'd7;
            end
            @(posedge clk); #1;       // edge k
            start = 1'b0;
            if (done) dcnt++;
            if (k == 8) chk("lockout p", p, 16'h0006);
            if (k >= 9) chk($sformatf("lockout idle e%0d", k), {15'd0, busy}, 16'd0);
        end
        chk("lockout done count", 16'(dcnt), 16'd1);
        chk("lockout p held", p, 16'h0006);

        // Back-to-back: start held high, operands change every cycle
        @(posedge clk); #1;
        start = 1'b1; a = 8'd3; b = 8'd1;
        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 0) begin
                opa[k / 10] = a;
                opb[k / 10] = b;
            end
            @(posedge clk); #1;       // edge k
            chk($sformatf("b2b done e%0d", k), {15'd0, done}, {15'd0, (k % 10 == 8)});
            if (k % 10 == 8) begin
                chk($sformatf("b2b p op%0d", k / 10), p,
                    16'(opa[k / 10]) * 16'(opb[k / 10]));
            end
            a = 8'((k + 1) * 7 + 3);
            b = 8'((k + 1) * 13 + 1);
            if (k == 29) start = 1'b0;
        end

        // Random pairs
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, 16'(ra) * 16'(rb), $sformatf("rnd%0d %0d*%0d", i, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
